// File: rtl/stream_gen.sv
// rtl/stream_gen.sv - deterministic valid/ready stimulus source with gap, count and seed
// Optional STREAM_GEN_LFSR_EN: data from a 32-bit Fibonacci LFSR instead of a counter.
module stream_gen #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DELAY = 0,
  parameter int unsigned COUNT = 0,
  parameter logic [63:0] SEED  = 64'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          down_valid,
  output logic [DW-1:0] down_data,
  input  logic          down_ready,
  output logic          done,
  output logic [31:0]   beat_cnt
);

  typedef enum logic [1:0] {
    S_GAP  = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] gap_q, gap_d;
  logic        xfer;

  assign xfer = valid_q && down_ready;

`ifdef STREAM_GEN_LFSR_EN
  // An all-zero LFSR never leaves zero, so a zero seed starts from 1.
  localparam logic [31:0] LFSR_INIT = (SEED[31:0] == 32'd0) ? 32'd1 : SEED[31:0];

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (xfer) begin
      lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign down_data = lfsr_q[DW-1:0];
`else
  localparam logic [DW-1:0] DATA_INIT = SEED[DW-1:0];

  logic [DW-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (xfer) begin
      data_d = data_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= DATA_INIT;
    end else begin
      data_q <= data_d;
    end
  end

  assign down_data = data_q;
`endif

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    done_d     = done_q;
    beat_cnt_d = beat_cnt_q;
    gap_d      = gap_q;
    case (state_q)
      S_GAP: begin
        if (en) begin
          // The edge that reaches DELAY idle cycles is also the edge that raises valid.
          if ((DELAY == 0) || (gap_q + 32'd1 == DELAY)) begin
            state_d = S_SEND;
            valid_d = 1'b1;
            gap_d   = 32'd0;
          end else begin
            gap_d = gap_q + 32'd1;
          end
        end
      end
      S_SEND: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          if ((COUNT != 0) && (beat_cnt_q + 32'd1 == COUNT)) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if ((DELAY == 0) && en) begin
            state_d = S_SEND;
            valid_d = 1'b1;
          end else begin
            state_d = S_GAP;
            valid_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_GAP;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_GAP;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      beat_cnt_q <= 32'd0;
      gap_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      beat_cnt_q <= beat_cnt_d;
      gap_q      <= gap_d;
    end
  end

  assign down_valid = valid_q;
  assign done       = done_q;
  assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_stream_gen.sv
// tb/tb_stream_gen.sv - directed self-checking bench for stream_gen
// With STREAM_GEN_LFSR_EN defined the LFSR sequence is checked instead of the counter.
module tb_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

`ifdef STREAM_GEN_LFSR_EN
  localparam logic [31:0] U0_INIT = 32'h1;
`else
  localparam logic [31:0] U0_INIT = 32'h0;
`endif

  logic        rst0 = 1'b0, en0 = 1'b0, rdy0 = 1'b0;
  logic        v0, done0;
  logic [31:0] d0, cnt0;
  logic        rst1 = 1'b0, en1 = 1'b0, rdy1 = 1'b0;
  logic        v1, done1;
  logic [31:0] d1, cnt1;
  logic        rst2 = 1'b0, en2 = 1'b0, rdy2 = 1'b0;
  logic        v2, done2;
  logic [7:0]  d2;
  logic [31:0] cnt2;

  stream_gen #(.DW(32), .DELAY(0), .COUNT(0), .SEED(64'h0)) u0 (
    .clk(clk), .rst(rst0), .en(en0), .down_valid(v0), .down_data(d0),
    .down_ready(rdy0), .done(done0), .beat_cnt(cnt0));

  stream_gen #(.DW(32), .DELAY(2), .COUNT(0), .SEED(64'h10)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .down_valid(v1), .down_data(d1),
    .down_ready(rdy1), .done(done1), .beat_cnt(cnt1));

  stream_gen #(.DW(8), .DELAY(0), .COUNT(4), .SEED(64'hFE)) u2 (
    .clk(clk), .rst(rst2), .en(en2), .down_valid(v2), .down_data(d2),
    .down_ready(rdy2), .done(done2), .beat_cnt(cnt2));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    en0 = 1'b1; rdy0 = 1'b1; en1 = 1'b1; rdy1 = 1'b1; en2 = 1'b1; rdy2 = 1'b1;
    step; step;
    total++; if (v0 !== 1'b0) $display("FAIL reset_valid got %b want 0", v0); else pass_cnt++;
    total++; if (d0 !== U0_INIT) $display("FAIL reset_data got %h want %h", d0, U0_INIT); else pass_cnt++;
    total++; if (done0 !== 1'b0) $display("FAIL reset_done got %b want 0", done0); else pass_cnt++;
    total++; if (cnt0 !== 32'd0) $display("FAIL reset_cnt got %0d want 0", cnt0); else pass_cnt++;
    total++; if (d1 !== 32'h10) $display("FAIL reset_seed1 got %h want 10", d1); else pass_cnt++;
    total++; if (d2 !== 8'hFE) $display("FAIL reset_seed2 got %h want fe", d2); else pass_cnt++;
  endtask

  task automatic test_delay0;
    rst0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      total++; if (v0 !== 1'b1) $display("FAIL d0_valid beat %0d got %b want 1", k, v0); else pass_cnt++;
      total++; if (d0 !== 32'(k)) $display("FAIL d0_data beat %0d got %0d want %0d", k, d0, k); else pass_cnt++;
      total++; if (cnt0 !== 32'(k)) $display("FAIL d0_cnt beat %0d got %0d want %0d", k, cnt0, k); else pass_cnt++;
      total++; if (done0 !== 1'b0) $display("FAIL d0_done beat %0d got %b want 0", k, done0); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    logic [7:0]  pat;
    logic [31:0] exp_v;
    pat   = 8'b1011_0100;
    exp_v = 32'd5;
    for (int i = 0; i < 8; i++) begin
      rdy0 = pat[i];
      step;
      if (pat[i]) exp_v++;
      total++; if (v0 !== 1'b1) $display("FAIL bp_valid i=%0d got %b want 1", i, v0); else pass_cnt++;
      total++; if (d0 !== exp_v) $display("FAIL bp_data i=%0d got %0d want %0d", i, d0, exp_v); else pass_cnt++;
      total++; if (cnt0 !== exp_v) $display("FAIL bp_cnt i=%0d got %0d want %0d", i, cnt0, exp_v); else pass_cnt++;
    end
    en0 = 1'b0; rdy0 = 1'b0;
    step;
    total++; if (v0 !== 1'b1) $display("FAIL send_ignores_en got %b want 1", v0); else pass_cnt++;
    rdy0 = 1'b1;
    step;
    exp_v++;
    total++; if (v0 !== 1'b0) $display("FAIL en_low_to_gap got %b want 0", v0); else pass_cnt++;
    total++; if (d0 !== exp_v) $display("FAIL en_low_data got %0d want %0d", d0, exp_v); else pass_cnt++;
    step;
    total++; if (v0 !== 1'b0) $display("FAIL gap_holds got %b want 0", v0); else pass_cnt++;
    en0 = 1'b1;
    step;
    total++; if (v0 !== 1'b1) $display("FAIL en_resume_valid got %b want 1", v0); else pass_cnt++;
    total++; if (d0 !== exp_v) $display("FAIL en_resume_data got %0d want %0d", d0, exp_v); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    rdy0 = 1'b0;
    step;
    total++; if (v0 !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", v0); else pass_cnt++;
    #2 rst0 = 1'b0;
    #1;
    total++; if (v0 !== 1'b0) $display("FAIL async_valid got %b want 0", v0); else pass_cnt++;
    total++; if (d0 !== 32'd0) $display("FAIL async_data got %0d want 0", d0); else pass_cnt++;
    total++; if (cnt0 !== 32'd0) $display("FAIL async_cnt got %0d want 0", cnt0); else pass_cnt++;
    step;
    rst0 = 1'b1; rdy0 = 1'b1;
    step;
    total++; if (v0 !== 1'b1 || d0 !== 32'd0) $display("FAIL restart_first got v=%b d=%0d want v=1 d=0", v0, d0); else pass_cnt++;
    step;
    total++; if (d0 !== 32'd1 || cnt0 !== 32'd1) $display("FAIL restart_second got d=%0d c=%0d want 1 1", d0, cnt0); else pass_cnt++;
  endtask

  task automatic test_gap;
    logic        ev [8];
    logic [31:0] exp_d;
    ev    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_d = 32'h10;
    rst1  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      total++; if (v1 !== ev[i]) $display("FAIL gap_valid i=%0d got %b want %b", i, v1, ev[i]); else pass_cnt++;
      if (ev[i]) begin
        total++; if (d1 !== exp_d) $display("FAIL gap_data i=%0d got %h want %h", i, d1, exp_d); else pass_cnt++;
        exp_d++;
      end
    end
    step; step;
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      total++; if (v1 !== 1'b0) $display("FAIL pause_valid i=%0d got %b want 0", i, v1); else pass_cnt++;
    end
    total++; if (cnt1 !== 32'd3) $display("FAIL pause_cnt got %0d want 3", cnt1); else pass_cnt++;
    en1 = 1'b1;
    step;
    total++; if (v1 !== 1'b1) $display("FAIL resume_valid got %b want 1", v1); else pass_cnt++;
    total++; if (d1 !== 32'h13) $display("FAIL resume_data got %h want 13", d1); else pass_cnt++;
  endtask

  task automatic test_count;
    logic [7:0] seq [4];
    seq  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      total++; if (v2 !== 1'b1) $display("FAIL cnt_valid i=%0d got %b want 1", i, v2); else pass_cnt++;
      total++; if (d2 !== seq[i]) $display("FAIL cnt_data i=%0d got %h want %h", i, d2, seq[i]); else pass_cnt++;
      total++; if (cnt2 !== 32'(i)) $display("FAIL cnt_beat i=%0d got %0d want %0d", i, cnt2, i); else pass_cnt++;
      total++; if (done2 !== 1'b0) $display("FAIL cnt_early_done i=%0d got %b want 0", i, done2); else pass_cnt++;
    end
    for (int i = 0; i < 21; i++) begin
      step;
      total++;
      if (v2 !== 1'b0 || done2 !== 1'b1 || cnt2 !== 32'd4 || d2 !== 8'h02)
        $display("FAIL done_hold i=%0d got v=%b done=%b cnt=%0d d=%h want v=0 done=1 cnt=4 d=02",
                 i, v2, done2, cnt2, d2);
      else pass_cnt++;
    end
    #2 rst2 = 1'b0;
    #1;
    total++; if (done2 !== 1'b0) $display("FAIL done_clear got %b want 0", done2); else pass_cnt++;
    total++; if (d2 !== 8'hFE || cnt2 !== 32'd0) $display("FAIL done_reset got d=%h c=%0d want fe 0", d2, cnt2); else pass_cnt++;
  endtask

`ifdef STREAM_GEN_LFSR_EN
  task automatic test_lfsr;
    logic [31:0] l;
    l    = 32'h1;
    rst0 = 1'b1; en0 = 1'b1; rdy0 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step;
      total++; if (d0 !== l) $display("FAIL lfsr beat %0d got %h want %h", i, d0, l); else pass_cnt++;
      l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    end
  endtask
`endif

  initial begin
    #1;
    test_reset;
`ifdef STREAM_GEN_LFSR_EN
    test_lfsr;
`else
    test_delay0;
    test_backpressure;
    test_reset_mid;
    test_gap;
    test_count;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
